// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants, digit types and controller states for the long multiplier datapath
package mult_pkg;

    localparam int WIDTH      = 16;
    localparam int L          = 4;
    localparam int INT_DIGITS = 2;
    localparam int MAX        = 10000;

    typedef logic [WIDTH-1:0] digit_t;
    typedef digit_t [L-1:0]   longnum_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or after ptr, wrapping modulo N
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);
    localparam int SW = IW + 1;

    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    logic [SW-1:0]  sum;

    // rot[i] is the request sitting i positions after the pointer
    assign req2 = {req, req} >> ptr;
    assign rot  = req2[N-1:0];

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        // walk from the farthest offset down so the nearest one wins
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = SW'(ptr) + SW'(i);
                if (sum >= SW'(N)) begin
                    sum = sum - SW'(N);
                end
                idx   = sum[IW-1:0];
                valid = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int j = 0; j < N; j++) begin
            grant[j] = valid && (idx == IW'(j));
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - round-robin sequencer sharing one mult_long between N requesters, with watchdog
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter int N       = 2,
    parameter int WIDTH   = mult_pkg::WIDTH,
    parameter int L       = mult_pkg::L,
    parameter int TIMEOUT = 64
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*L*WIDTH-1:0] a_in,
    input  logic [N*L*WIDTH-1:0] b_in,
    output logic [N-1:0]         ack,
    output logic [N-1:0]         done,
    output logic [L*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 busy,
    output logic [L*WIDTH-1:0]   mult_a,
    output logic [L*WIDTH-1:0]   mult_b,
    output logic                 mult_rst,
    input  logic                 mult_finish,
    input  logic [L*WIDTH-1:0]   mult_c
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam int NW = L * WIDTH;

    ctrl_state_t   state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_id;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_onehot;
    logic          win_valid;
    logic [CW-1:0] wdog;
    logic [NW-1:0] a_req [N];
    logic [NW-1:0] b_req [N];

    for (genvar i = 0; i < N; i++) begin : g_split
        assign a_req[i] = a_in[i*NW +: NW];
        assign b_req[i] = b_in[i*NW +: NW];
    end

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (win_onehot),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_ff @(posedge ck) begin
        if (rst) begin
            state    <= IDLE;
            ack      <= '0;
            done     <= '0;
            result   <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            mult_a   <= '0;
            mult_b   <= '0;
            mult_rst <= 1'b1;
            ptr      <= '0;
            gnt_id   <= '0;
            wdog     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_valid) begin
                        mult_a <= a_req[win_idx];
                        mult_b <= b_req[win_idx];
                        gnt_id <= win_idx;
                        ack    <= win_onehot;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // multiplier has been held in reset for a cycle, so its finish flag is clear
                    ack      <= '0;
                    mult_rst <= 1'b0;
                    wdog     <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    wdog <= wdog + 1'b1;
                    if (mult_finish) begin
                        result       <= mult_c;
                        done[gnt_id] <= 1'b1;
                        state        <= DONE;
                    end else if (wdog == CW'(TIMEOUT - 1)) begin
                        err          <= 1'b1;
                        result       <= '0;
                        done[gnt_id] <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    done     <= '0;
                    mult_rst <= 1'b1;
                    busy     <= 1'b0;
                    ptr      <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - self-checking bench for mult_share_ctrl with a behavioural mult_long model
module tb_mult_share_ctrl;
    import mult_pkg::*;

    localparam int N       = 2;
    localparam int TIMEOUT = 64;
    localparam int NW      = L * WIDTH;
    localparam int LAT     = L * (L + 1);

    logic             ck = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*NW-1:0]  a_in;
    logic [N*NW-1:0]  b_in;
    logic [N-1:0]     ack;
    logic [N-1:0]     done;
    logic [NW-1:0]    result;
    logic             err;
    logic             busy;
    logic [NW-1:0]    mult_a;
    logic [NW-1:0]    mult_b;
    logic             mult_rst;
    logic             mult_finish = 1'b0;
    logic [NW-1:0]    mult_c = '0;

    logic             stub = 1'b0;
    int               mcnt = 0;
    int               n_checks = 0;
    int               n_fail = 0;
    int               ptr_model = 0;
    logic             err_model = 1'b0;
    logic [NW-1:0]    opa [N];
    logic [NW-1:0]    opb [N];

    mult_share_ctrl #(
        .N       (N),
        .WIDTH   (WIDTH),
        .L       (L),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ck          (ck),
        .rst         (rst),
        .req         (req),
        .a_in        (a_in),
        .b_in        (b_in),
        .ack         (ack),
        .done        (done),
        .result      (result),
        .err         (err),
        .busy        (busy),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_rst    (mult_rst),
        .mult_finish (mult_finish),
        .mult_c      (mult_c)
    );

    always #5 ck = ~ck;

    // fixed-point product: full schoolbook product in base MAX, drop the fractional digits, keep L
    function automatic logic [NW-1:0] fx_mul(input logic [NW-1:0] a, input logic [NW-1:0] b);
        longint unsigned p [2*L];
        logic [NW-1:0]   r;
        for (int k = 0; k < 2 * L; k++) p[k] = 0;
        for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++)
                p[i+j] += 64'(a[i*WIDTH +: WIDTH]) * 64'(b[j*WIDTH +: WIDTH]);
        for (int k = 0; k < 2 * L - 1; k++) begin
            p[k+1] += p[k] / MAX;
            p[k]    = p[k] % MAX;
        end
        r = '0;
        for (int i = 0; i < L; i++)
            r[i*WIDTH +: WIDTH] = WIDTH'(p[i + L - INT_DIGITS] % MAX);
        return r;
    endfunction

    // stand-in for mult_long: finishes LAT cycles after reset release, flag sticky until reset
    always_ff @(posedge ck) begin
        if (mult_rst) begin
            mcnt        <= 0;
            mult_finish <= 1'b0;
        end else begin
            mcnt <= mcnt + 1;
            if (!stub && mcnt == LAT - 1) begin
                mult_finish <= 1'b1;
                mult_c      <= fx_mul(mult_a, mult_b);
            end
        end
    end

    function automatic logic [NW-1:0] rand_num();
        logic [NW-1:0] r;
        for (int i = 0; i < L; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, MAX - 1));
        return r;
    endfunction

    function automatic logic [N-1:0] onehot(input int r);
        logic [N-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic int model_pick(input logic [N-1:0] pend);
        for (int k = 0; k < N; k++)
            if (pend[(ptr_model + k) % N]) return (ptr_model + k) % N;
        return 0;
    endfunction

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic check(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check(tag, "ack", 64'(ack), 64'd0);
        check(tag, "done", 64'(done), 64'd0);
        check(tag, "result", result, 64'd0);
        check(tag, "err", 64'(err), 64'd0);
        check(tag, "busy", 64'(busy), 64'd0);
        check(tag, "mult_a", mult_a, 64'd0);
        check(tag, "mult_b", mult_b, 64'd0);
        check(tag, "mult_rst", 64'(mult_rst), 64'd1);
    endtask

    task automatic wait_ack(output logic [N-1:0] seen);
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ack != '0) begin
                seen = ack;
                break;
            end
        end
    endtask

    // counts cycles from the ack cycle to the done cycle; glitch counts RUN cycles that misbehave
    task automatic wait_done(input int late_r, input logic [NW-1:0] ea, input logic [NW-1:0] eb,
                             output int lat, output bit ok, output int glitch);
        lat    = 0;
        ok     = 1'b0;
        glitch = 0;
        for (int i = 0; i < 4 * TIMEOUT; i++) begin
            step();
            lat++;
            if (late_r >= 0 && lat == 5) req[late_r] = 1'b1;
            if (done != '0) begin
                ok = 1'b1;
                break;
            end
            if (ack != '0 || mult_a !== ea || mult_b !== eb || mult_rst !== 1'b0 || busy !== 1'b1)
                glitch++;
        end
    endtask

    task automatic serve(input int r, input logic [NW-1:0] a, input logic [NW-1:0] b,
                         input bit stub_mode, input int late_r, input string tag);
        logic [NW-1:0] exp;
        int            lat;
        int            glitch;
        bit            ok;
        exp = stub_mode ? '0 : fx_mul(a, b);
        if (stub_mode) err_model = 1'b1;
        a_in[r*NW +: NW] = a;
        b_in[r*NW +: NW] = b;
        req[r] = 1'b1;
        step();
        check(tag, "ack", 64'(ack), 64'(onehot(r)));
        check(tag, "mult_a", mult_a, a);
        check(tag, "mult_b", mult_b, b);
        check(tag, "mult_rst_load", 64'(mult_rst), 64'd1);
        check(tag, "busy", 64'(busy), 64'd1);
        req[r] = 1'b0;
        a_in[r*NW +: NW] = rand_num();
        b_in[r*NW +: NW] = rand_num();
        wait_done(late_r, a, b, lat, ok, glitch);
        check(tag, "done_seen", 64'(ok), 64'd1);
        check(tag, "done", 64'(done), 64'(onehot(r)));
        check(tag, "result", result, exp);
        check(tag, "latency", 64'(lat), stub_mode ? 64'(TIMEOUT + 1) : 64'(LAT + 2));
        check(tag, "run_quiet", 64'(glitch), 64'd0);
        check(tag, "err", 64'(err), 64'(err_model));
        ptr_model = (r + 1) % N;
        step();
        check(tag, "done_clear", 64'(done), 64'd0);
        check(tag, "idle", 64'(busy), 64'd0);
        check(tag, "result_hold", result, exp);
        check(tag, "mult_rst_idle", 64'(mult_rst), 64'd1);
    endtask

    // hold=1: requests stay high throughout; hold=0: each requester drops its req once acked
    task automatic drain(input logic [N-1:0] mask, input int ntx, input bit hold, input string tag);
        logic [N-1:0] pend;
        logic [N-1:0] seen;
        int           g;
        int           lat;
        int           glitch;
        bit           ok;
        pend = mask;
        for (int i = 0; i < N; i++) begin
            a_in[i*NW +: NW] = opa[i];
            b_in[i*NW +: NW] = opb[i];
        end
        req = mask;
        for (int t = 0; t < ntx; t++) begin
            g = model_pick(pend);
            wait_ack(seen);
            check(tag, "grant", 64'(seen), 64'(onehot(g)));
            check(tag, "mult_a", mult_a, opa[g]);
            check(tag, "mult_b", mult_b, opb[g]);
            if (!hold) begin
                req[g]  = 1'b0;
                pend[g] = 1'b0;
            end
            wait_done(-1, opa[g], opb[g], lat, ok, glitch);
            check(tag, "done", 64'(done), 64'(onehot(g)));
            check(tag, "result", result, fx_mul(opa[g], opb[g]));
            check(tag, "latency", 64'(lat), 64'(LAT + 2));
            check(tag, "run_quiet", 64'(glitch), 64'd0);
            ptr_model = (g + 1) % N;
            step();
        end
        req = '0;
    endtask

    initial begin
        longnum_t     na;
        longnum_t     nb;
        logic [N-1:0] mask;
        logic [N-1:0] any_done;

        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        step();
        step();
        rst = 1'b0;
        check_reset("reset");

        na = {16'd0, 16'd1, 16'd0, 16'd0};
        nb = {16'd0, 16'd2, 16'd5000, 16'd0};
        serve(0, na, nb, 1'b0, -1, "single");
        check("single", "value", result, 64'({16'd0, 16'd2, 16'd5000, 16'd0}));

        na = {16'd0, 16'd0, 16'd5000, 16'd0};
        serve(1, na, na, 1'b0, -1, "carry");
        check("carry", "value", result, 64'({16'd0, 16'd0, 16'd2500, 16'd0}));

        for (int i = 0; i < N; i++) begin
            opa[i] = rand_num();
            opb[i] = rand_num();
        end
        drain('1, 4, 1'b1, "fair");

        a_in[1*NW +: NW] = rand_num();
        b_in[1*NW +: NW] = rand_num();
        opa[1] = a_in[1*NW +: NW];
        opb[1] = b_in[1*NW +: NW];
        serve(0, rand_num(), rand_num(), 1'b0, 1, "late_first");
        serve(1, opa[1], opb[1], 1'b0, -1, "late_next");

        for (int it = 0; it < 5; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                opa[i] = rand_num();
                opb[i] = rand_num();
            end
            drain(mask, $countones(mask), 1'b0, "rand");
        end

        stub = 1'b1;
        serve(0, rand_num(), rand_num(), 1'b1, -1, "watchdog");
        stub = 1'b0;
        serve(0, rand_num(), rand_num(), 1'b0, -1, "after_wdog");

        // requester 1 in flight with the pointer at 1; only a reset can bring requester 0 to the front
        a_in[1*NW +: NW] = rand_num();
        b_in[1*NW +: NW] = rand_num();
        req[1] = 1'b1;
        step();
        check("midrst", "ack", 64'(ack), 64'(onehot(1)));
        req[1] = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        err_model = 1'b0;
        ptr_model = 0;
        check_reset("midrst");
        any_done = '0;
        for (int i = 0; i < 2 * LAT; i++) begin
            step();
            any_done |= done;
        end
        check("midrst", "no_done", 64'(any_done), 64'd0);
        for (int i = 0; i < N; i++) begin
            opa[i] = rand_num();
            opb[i] = rand_num();
        end
        drain('1, N, 1'b0, "post_rst");
        check("post_rst", "err", 64'(err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed stalled bench expected completion");
        $fatal(1, "timeout");
    end

endmodule
